mem_port_arbiter: RTL and testbench

Parametrised multi-channel successor to the single instruction/data memory controller. Accepts up to NCH independent byte-length requests (icache, dcache/MEM stage, future prefetcher), arbitrates, and serialises each into byte transfers on the 8-bit RAM/IO bus (1-cycle read latency, 0-cycle write). Sits between the pipeline-side request ports and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic {IDLE, XFER} state_t;
    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;
    localparam logic [1:0] IO_SEL = 2'b11;
    function automatic logic [2:0] eff_len(input logic [31:0] l);
        return l == 32'(LEN_B) ? LEN_B : l == 32'(LEN_H) ? LEN_H : LEN_W;
    endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: request picker, fixed priority or round-robin when MEM_ARB_RR_EN is defined
module arb_pick #(
    parameter int NCH = 2,
    parameter int IW = 1
) (
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic adv,
`endif
    input  logic [NCH-1:0] reqv,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);
`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] ptr;
    // move the search start just past the channel that was granted
    always_ff @(posedge clk)
        if (rst) ptr <= '0;
        else if (adv) ptr <= int'(idx) == NCH - 1 ? '0 : idx + 1'b1;
    // first requester at or after ptr, wrapping around
    always_comb begin
        idx = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (reqv[(int'(ptr) + k) % NCH]) idx = IW'((int'(ptr) + k) % NCH);
    end
`else
    // lowest requesting index wins
    always_comb begin
        idx = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (reqv[k]) idx = IW'(k);
    end
`endif
    assign gnt = |reqv ? NCH'(1) << idx : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NCH-channel request arbiter serialising byte transfers onto the RAM/IO bus (MEM_ARB_RR_EN selects round-robin)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCH = 2,
    parameter int ADDR_W = 32,
    parameter int LEN_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        wr,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*LEN_W-1:0]  len,
    input  logic [NCH*32-1:0]     wdata,
    input  logic [NCH-1:0]        flush,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done,
    output logic [31:0]           rdata,
    input  logic [7:0]            ram_in,
    output logic [7:0]            ram_out,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_wr,
    input  logic                  io_buffer_full
);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    state_t state, state_n;
    logic [2:0] cnt, cnt_n, len_q, idx;
    logic [IW-1:0] ch_q, gidx;
    logic wr_q, xfer, take, stall, fin, cap;
    logic [ADDR_W-1:0] addr_q, ba, last_addr;
    logic [31:0] wdata_q, rbuf, rbuf_n;
    logic [1:0] bi;
    logic [NCH-1:0] elig, gnt;

    assign elig = req & ~flush;
    assign xfer = state == XFER;
    assign take = state == IDLE && rdy && |gnt;
    assign idx = cnt == len_q ? cnt - 3'd1 : cnt;
    assign ba = addr_q + ADDR_W'(idx);
    assign stall = wr_q && ba[17:16] == IO_SEL && io_buffer_full;
    assign cap = xfer && !wr_q && !flush[ch_q] && cnt != 3'd0;
    assign bi = 2'(cnt - 3'd1);
    assign busy = xfer ? NCH'(1) << ch_q : '0;
    assign ram_addr = !rdy ? last_addr : xfer ? ba : '0;
    assign ram_wr = rdy && xfer && wr_q && !stall;
    assign ram_out = xfer && wr_q ? wdata_q[8*cnt[1:0] +: 8] : '0;

    arb_pick #(.NCH(NCH), .IW(IW)) u_pick (
`ifdef MEM_ARB_RR_EN
        .clk(clk),
        .rst(rst),
        .adv(take),
`endif
        .reqv(elig),
        .gnt(gnt),
        .idx(gidx)
    );

    // next state: reads run one extra cycle to catch the last returned byte
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        fin = 1'b0;
        if (state == IDLE) begin
            state_n = take ? XFER : IDLE;
            cnt_n = take ? 3'd0 : cnt;
        end else if (wr_q) begin
            cnt_n = stall ? cnt : cnt + 3'd1;
            fin = !stall && cnt == len_q - 3'd1;
        end else if (flush[ch_q]) begin
            state_n = IDLE;
        end else begin
            cnt_n = cnt + 3'd1;
            fin = cnt == len_q;
        end
        if (fin) state_n = IDLE;
    end

    // merge the byte returned this cycle into the read buffer
    always_comb begin
        rbuf_n = rbuf;
        rbuf_n[8*bi +: 8] = ram_in;
    end

    // state register, frozen while rdy is low
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else if (rdy) begin
            state <= state_n;
            cnt <= cnt_n;
        end

    // request latch, read assembly, completion pulse; last_addr keeps the bus address steady across stalls
    always_ff @(posedge clk)
        if (rst) begin
            done <= '0;
            rdata <= '0;
            rbuf <= '0;
            last_addr <= '0;
            ch_q <= '0;
            wr_q <= 1'b0;
            addr_q <= '0;
            len_q <= '0;
            wdata_q <= '0;
        end else begin
            last_addr <= ram_addr;
            if (rdy) begin
                done <= fin ? busy : '0;
                if (take) begin
                    ch_q <= gidx;
                    wr_q <= wr[gidx];
                    addr_q <= addr[gidx*ADDR_W +: ADDR_W];
                    len_q <= eff_len(32'(len[gidx*LEN_W +: LEN_W]));
                    wdata_q <= wdata[gidx*32 +: 32];
                    rbuf <= '0;
                end
                if (cap) rbuf <= rbuf_n;
                if (cap && fin) rdata <= rbuf_n;
            end
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic [1:0] req = '0, wr = '0, flush = '0, busy, done;
    logic [63:0] addr = '0, wdata = '0;
    logic [5:0] len = '0;
    logic [31:0] rdata, ram_addr;
    logic [7:0] ram_in, ram_out;
    logic ram_wr;
    logic io_buffer_full = 1'b0;
    logic [31:0] wv = 32'hDDCCBBAA;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req), .wr(wr), .addr(addr),
        .len(len), .wdata(wdata), .flush(flush), .busy(busy), .done(done),
        .rdata(rdata), .ram_in(ram_in), .ram_out(ram_out), .ram_addr(ram_addr),
        .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
    );

    // RAM content: byte at a is 0x11 * (a[1:0] + 1)
    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [7:0] n;
        n = {6'b0, a[1:0]} + 8'd1;
        return n * 8'h11;
    endfunction

    // one-cycle read latency RAM
    always @(posedge clk) ram_in <= rbyte(ram_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    function automatic logic [1:0] cch(input int k);
        return RR ? 2'(k % 2) : 2'd0;
    endfunction

    initial begin
        cyc;
        cyc;
        rst = 1'b0;
        smp;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst rdata", rdata, 0);
        check("rst ram_addr", ram_addr, 0);
        check("rst ram_out", 32'(ram_out), 0);
        check("rst ram_wr", 32'(ram_wr), 0);

        // ch1 read of 4 bytes at 0x100
        cyc;
        req = 2'b10;
        addr[63:32] = 32'h100;
        len[5:3] = 3'd4;
        smp;
        check("A busy0", 32'(busy), 0);
        for (int c = 1; c <= 6; c++) begin
            cyc;
            if (c == 6) req = '0;
            smp;
            if (c <= 4) begin
                check("A addr", ram_addr, 32'h100 + 32'(c - 1));
                check("A busy", 32'(busy), 2);
            end
            if (c == 5) check("A early done", 32'(done), 0);
        end
        check("A done", 32'(done), 2);
        check("A rdata", rdata, 32'h44332211);
        check("A idle ram_addr", ram_addr, 0);

        // ch0 write of 2 bytes to IO with the TX buffer full for three cycles
        cyc;
        req = 2'b01;
        wr = 2'b01;
        addr[31:0] = 32'h30000;
        len[2:0] = 3'd2;
        wdata[31:0] = 32'h4142;
        for (int c = 1; c <= 6; c++) begin
            cyc;
            io_buffer_full = c <= 3;
            if (c == 6) req = '0;
            smp;
            if (c <= 3) check("B stall wr", 32'(ram_wr), 0);
            if (c == 4 || c == 5) begin
                check("B wr", 32'(ram_wr), 1);
                check("B out", 32'(ram_out), c == 4 ? 32'h42 : 32'h41);
                check("B addr", ram_addr, 32'h30000 + 32'(c - 4));
            end
            if (c == 5) check("B early done", 32'(done), 0);
        end
        check("B done", 32'(done), 1);
        check("B idle wr", 32'(ram_wr), 0);

        // both channels requesting continuously, single-byte reads
        cyc;
        rst = 1'b1;
        wr = '0;
        cyc;
        rst = 1'b0;
        req = 2'b11;
        addr = {32'h301, 32'h200};
        len = {3'd1, 3'd1};
        for (int c = 1; c <= 12; c++) begin
            cyc;
            if (c == 12) req = '0;
            smp;
            if (c % 3 == 1) check("C grant", 32'(busy), 32'(2'd1 << cch((c - 1) / 3)));
            if (c % 3 == 0) begin
                check("C done", 32'(done), 32'(2'd1 << cch(c / 3 - 1)));
                check("C rdata", rdata, cch(c / 3 - 1) == 2'd1 ? 32'h22 : 32'h11);
            end
        end

        // ch0 read flushed mid-transfer, ch1 pending behind it
        cyc;
        req = 2'b11;
        addr = {32'h202, 32'h100};
        len = {3'd2, 3'd4};
        for (int c = 1; c <= 7; c++) begin
            cyc;
            if (c == 2) flush = 2'b01;
            if (c == 3) begin
                flush = '0;
                req = 2'b10;
            end
            if (c == 7) req = '0;
            smp;
            if (c == 2) check("D busy ch0", 32'(busy), 1);
            if (c == 3) begin
                check("D flush busy", 32'(busy), 0);
                check("D flush done", 32'(done), 0);
                check("D flush rdata", rdata, RR ? 32'h22 : 32'h11);
            end
            if (c == 4) begin
                check("D ch1 busy", 32'(busy), 2);
                check("D ch1 addr", ram_addr, 32'h202);
            end
        end
        check("D done", 32'(done), 2);
        check("D rdata", rdata, 32'h4433);

        // ch0 read of 2 bytes at 0x101 with rdy low in cycle 2
        cyc;
        req = 2'b01;
        addr[31:0] = 32'h101;
        len[2:0] = 3'd2;
        for (int c = 1; c <= 5; c++) begin
            cyc;
            rdy = c != 2;
            if (c == 5) req = '0;
            smp;
            if (c <= 2) check("E addr", ram_addr, 32'h101);
            if (c == 2) check("E frozen wr", 32'(ram_wr), 0);
            if (c == 3) check("E resume addr", ram_addr, 32'h102);
            if (c == 4) check("E delayed done", 32'(done), 0);
        end
        check("E done", 32'(done), 1);
        check("E rdata", rdata, 32'h3322);

        // ch1 write of 4 bytes cut by reset, then re-served with len 7 (treated as 4)
        cyc;
        req = 2'b10;
        wr = 2'b10;
        addr[63:32] = 32'h400;
        len[5:3] = 3'd4;
        wdata[63:32] = wv;
        for (int c = 1; c <= 9; c++) begin
            cyc;
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                rst = 1'b0;
                len[5:3] = 3'd7;
            end
            if (c == 9) req = '0;
            smp;
            if (c <= 2) check("F out", 32'(ram_out), 32'(wv[8*(c-1) +: 8]));
            if (c == 4) begin
                check("F rst wr", 32'(ram_wr), 0);
                check("F rst addr", ram_addr, 0);
                check("F rst out", 32'(ram_out), 0);
                check("F rst busy", 32'(busy), 0);
                check("F rst done", 32'(done), 0);
            end
            if (c >= 5 && c <= 8) begin
                check("F re addr", ram_addr, 32'h400 + 32'(c - 5));
                check("F re out", 32'(ram_out), 32'(wv[8*(c-5) +: 8]));
                check("F re wr", 32'(ram_wr), 1);
            end
        end
        check("F done", 32'(done), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
